// File: rtl/merge16_sched.sv
`default_nettype none
// ============================================================================
// Module      : merge16_sched
// Description : Shares one merge16 sorter across NGROUPS groups of 16 cluster
//               candidates. Issues non-empty groups in ascending order, tracks
//               the sorter latency with a tag pipe and registers each group's
//               sorted top-8 result as a tagged output beat.
// Revision    : 1.0 - initial release
// ============================================================================
module merge16_sched #(
    parameter int NGROUPS   = 4,
    parameter int LATENCY   = 3,
    parameter int MXADRBITS = 11,
    parameter int MXCNTBITS = 3
) (
    input  logic                         clock4x,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic [NGROUPS-1:0]           grp_mask,
    output logic [$clog2(NGROUPS)-1:0]   mrg_sel,
    output logic                         mrg_issue,
    input  logic [8*MXADRBITS-1:0]       mrg_adr,
    input  logic [8*MXCNTBITS-1:0]       mrg_cnt,
    output logic                         res_valid,
    output logic [$clog2(NGROUPS)-1:0]   res_grp,
    output logic                         res_last,
    output logic [8*MXADRBITS-1:0]       res_adr,
    output logic [8*MXCNTBITS-1:0]       res_cnt,
    output logic                         busy,
    output logic                         done,
    output logic                         overrun
);

    localparam int GRPBITS = $clog2(NGROUPS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               state_q;
    logic [NGROUPS-1:0]   mask_q;
    logic [GRPBITS-1:0]   mrg_sel_q;
    logic                 mrg_issue_q;
    logic                 issue_last_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 overrun_q;

    logic [LATENCY-1:0]   tag_vld_q;
    logic [LATENCY-1:0]   tag_last_q;
    logic [GRPBITS-1:0]   tag_grp_q [LATENCY];

    logic                 res_valid_q;
    logic [GRPBITS-1:0]   res_grp_q;
    logic                 res_last_q;
    logic [8*MXADRBITS-1:0] res_adr_q;
    logic [8*MXCNTBITS-1:0] res_cnt_q;

    logic [NGROUPS-1:0]   src_mask_d;
    logic [NGROUPS-1:0]   rem_mask_d;
    logic [GRPBITS-1:0]   sel_d;
    logic                 last_d;
    logic                 pipe_busy_d;

    // Pick the lowest pending group; in IDLE the fresh mask is used so the
    // first issue is registered on the very edge that accepts start.
    always_comb begin
        src_mask_d = (state_q == S_IDLE) ? grp_mask : mask_q;
        sel_d      = '0;
        for (int g = NGROUPS - 1; g >= 0; g--) begin
            if (src_mask_d[g]) begin
                sel_d = GRPBITS'(g);
            end
        end
        rem_mask_d  = src_mask_d & (src_mask_d - NGROUPS'(1));
        last_d      = (rem_mask_d == '0);
        pipe_busy_d = mrg_issue_q | (|tag_vld_q);
    end

    // Pass sequencer with registered issue/status outputs.
    always_ff @(posedge clock4x or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            mask_q       <= '0;
            mrg_sel_q    <= '0;
            mrg_issue_q  <= 1'b0;
            issue_last_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            mrg_issue_q  <= 1'b0;
            issue_last_q <= 1'b0;
            done_q       <= 1'b0;
            overrun_q    <= start && (state_q != S_IDLE);
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mask_q <= rem_mask_d;
                        busy_q <= 1'b1;
                        if (grp_mask != '0) begin
                            mrg_sel_q    <= sel_d;
                            mrg_issue_q  <= 1'b1;
                            issue_last_q <= last_d;
                            state_q      <= last_d ? S_DRAIN : S_ISSUE;
                        end else begin
                            // Empty pass still walks through DRAIN so done
                            // lands two cycles after start.
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_ISSUE: begin
                    mrg_sel_q    <= sel_d;
                    mrg_issue_q  <= 1'b1;
                    issue_last_q <= last_d;
                    mask_q       <= rem_mask_d;
                    if (last_d) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!pipe_busy_d) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Tag pipe: mirrors the sorter latency, fed from the registered issue.
    always_ff @(posedge clock4x or negedge reset_n) begin
        if (!reset_n) begin
            tag_vld_q  <= '0;
            tag_last_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                tag_grp_q[i] <= '0;
            end
        end else begin
            tag_vld_q[0]  <= mrg_issue_q;
            tag_last_q[0] <= issue_last_q;
            tag_grp_q[0]  <= mrg_sel_q;
            for (int i = 1; i < LATENCY; i++) begin
                tag_vld_q[i]  <= tag_vld_q[i-1];
                tag_last_q[i] <= tag_last_q[i-1];
                tag_grp_q[i]  <= tag_grp_q[i-1];
            end
        end
    end

    // Result capture: sorter outputs are sampled only when a tag matures.
    always_ff @(posedge clock4x or negedge reset_n) begin
        if (!reset_n) begin
            res_valid_q <= 1'b0;
            res_grp_q   <= '0;
            res_last_q  <= 1'b0;
            res_adr_q   <= {(8*MXADRBITS){1'b1}};
            res_cnt_q   <= '0;
        end else begin
            res_valid_q <= tag_vld_q[LATENCY-1];
            res_last_q  <= tag_vld_q[LATENCY-1] & tag_last_q[LATENCY-1];
            if (tag_vld_q[LATENCY-1]) begin
                res_grp_q <= tag_grp_q[LATENCY-1];
                res_adr_q <= mrg_adr;
                res_cnt_q <= mrg_cnt;
            end
        end
    end

    assign mrg_sel   = mrg_sel_q;
    assign mrg_issue = mrg_issue_q;
    assign res_valid = res_valid_q;
    assign res_grp   = res_grp_q;
    assign res_last  = res_last_q;
    assign res_adr   = res_adr_q;
    assign res_cnt   = res_cnt_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign overrun   = overrun_q;

endmodule
`default_nettype wire
